// File: rtl/rv64_exec_slice.sv
// RV64I integer execute slice: combinational decoder, 32x64 register file and
// 64-bit ALU; the result is written back at the same edge that retires it.
module rv64_exec_slice #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  input  logic [31:0]     instruction,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [31:0]     immediate,
  output logic [3:0]      alu_op,
  output logic [5:0]      shamt,
  output logic            illegal,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] result,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            use_imm;
  logic            is_w;
  logic            w_shift;
  alu_op_e         op;
  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_rs2;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] full_value;
  logic [31:0]     word_value;
  logic [XLEN-1:0] alu_value;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];
  assign rd     = instruction[11:7];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign alu_op = op;

  assign w_shift = (opcode == OPC_OP_32 || opcode == OPC_OP_IMM_32) &&
                   (funct3 == 3'd1 || funct3 == 3'd5);
  assign shamt   = {instruction[25] & ~w_shift, instruction[24:20]};

  // funct3 selects the operation; alt picks SUB over ADD and SRA over SRL.
  function automatic alu_op_e f3_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    f3_op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    f3_op = ALU_SLL;
      3'd2:    f3_op = ALU_SLT;
      3'd3:    f3_op = ALU_SLTU;
      3'd4:    f3_op = ALU_XOR;
      3'd5:    f3_op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    f3_op = ALU_OR;
      default: f3_op = ALU_AND;
    endcase
  endfunction

  always_comb begin
    op        = ALU_ADD;
    illegal   = 1'b1;
    immediate = '0;
    use_imm   = 1'b0;
    is_w      = 1'b0;
    case (opcode)
      OPC_OP: begin
        op      = f3_op(funct3, funct7[5]);
        illegal = !(funct7 == 7'h00 ||
                    (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5)));
      end
      OPC_OP_IMM: begin
        immediate = {{20{instruction[31]}}, instruction[31:20]};
        use_imm   = 1'b1;
        op        = f3_op(funct3, funct3 == 3'd5 && instruction[30]);
        if (funct3 == 3'd1)
          illegal = instruction[31:26] != 6'h00;
        else if (funct3 == 3'd5)
          illegal = !(instruction[31:26] == 6'h00 || instruction[31:26] == 6'h10);
        else
          illegal = 1'b0;
      end
      OPC_OP_32: begin
        is_w    = 1'b1;
        op      = f3_op(funct3, funct7[5]);
        illegal = !((funct3 == 3'd0 && (funct7 == 7'h00 || funct7 == 7'h20)) ||
                    (funct3 == 3'd1 && funct7 == 7'h00) ||
                    (funct3 == 3'd5 && (funct7 == 7'h00 || funct7 == 7'h20)));
      end
      OPC_OP_IMM_32: begin
        immediate = {{20{instruction[31]}}, instruction[31:20]};
        use_imm   = 1'b1;
        is_w      = 1'b1;
        op        = f3_op(funct3, funct3 == 3'd5 && funct7[5]);
        illegal   = !(funct3 == 3'd0 ||
                      (funct3 == 3'd1 && funct7 == 7'h00) ||
                      (funct3 == 3'd5 && (funct7 == 7'h00 || funct7 == 7'h20)));
      end
      OPC_LUI: begin
        immediate = {instruction[31:12], 12'h000};
        use_imm   = 1'b1;
        op        = ALU_PASSB;
        illegal   = 1'b0;
      end
      default: ;
    endcase
  end

  // Immediate shifts carry shamt in imm[5:0], so B's low bits cover both forms.
  assign src_a   = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign src_rs2 = (rs2 == 5'd0) ? '0 : regs[rs2];
  assign src_b   = use_imm ? {{(XLEN-32){immediate[31]}}, immediate} : src_rs2;

  always_comb begin
    full_value = src_a + src_b;
    word_value = src_a[31:0] + src_b[31:0];
    case (op)
      ALU_SUB: begin
        full_value = src_a - src_b;
        word_value = src_a[31:0] - src_b[31:0];
      end
      ALU_SLL: begin
        full_value = src_a << src_b[5:0];
        word_value = src_a[31:0] << src_b[4:0];
      end
      ALU_SLT:   full_value = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_SLTU:  full_value = {{(XLEN-1){1'b0}}, src_a < src_b};
      ALU_XOR:   full_value = src_a ^ src_b;
      ALU_SRL: begin
        full_value = src_a >> src_b[5:0];
        word_value = src_a[31:0] >> src_b[4:0];
      end
      ALU_SRA: begin
        full_value = $signed(src_a) >>> src_b[5:0];
        word_value = $signed(src_a[31:0]) >>> src_b[4:0];
      end
      ALU_OR:    full_value = src_a | src_b;
      ALU_AND:   full_value = src_a & src_b;
      ALU_PASSB: full_value = src_b;
      default: ;
    endcase
  end

  assign alu_value = is_w ? {{(XLEN-32){word_value[31]}}, word_value} : full_value;

  // x0 is never written, so its storage stays zero after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      result   <= '0;
      wb_rd    <= '0;
      wb_valid <= 1'b0;
    end else if (instr_valid && !illegal) begin
      if (rd != 5'd0) regs[rd] <= alu_value;
      result   <= alu_value;
      wb_rd    <= rd;
      wb_valid <= 1'b1;
    end else begin
      wb_valid <= 1'b0;
    end
  end

  assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

endmodule

// File: tb/tb_rv64_exec_slice.sv
// Randomized self-checking bench for rv64_exec_slice against an instruction-level
// reference model of the RV64I subset it executes.
module tb_rv64_exec_slice;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] immediate;
  logic [3:0]  alu_op;
  logic [5:0]  shamt;
  logic        illegal;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] result;
  logic [4:0]  dbg_addr;
  logic [63:0] dbg_data;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_regs [32];
  logic [63:0] m_result;
  logic [4:0]  m_wb_rd;
  logic        m_wb_valid;
  bit          m_known = 0;

  typedef enum int {
    ADD, SUB, SLL, SLT, SLTU, XOR_, SRL, SRA, OR_, AND_,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADDW, SUBW, SLLW, SRLW, SRAW, ADDIW, SLLIW, SRLIW, SRAIW, LUI, BAD
  } mnem_e;

  rv64_exec_slice dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instruction(instruction),
    .rd(rd), .rs1(rs1), .rs2(rs2), .immediate(immediate), .alu_op(alu_op),
    .shamt(shamt), .illegal(illegal), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .result(result), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2,
      input logic [4:0] r1, input logic [2:0] f3, input logic [4:0] d, input logic [6:0] opc);
    return {f7, r2, r1, f3, d, opc};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1,
      input logic [2:0] f3, input logic [4:0] d, input logic [6:0] opc);
    return {imm, r1, f3, d, opc};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] d,
      input logic [6:0] opc);
    return {imm, d, opc};
  endfunction

  function automatic logic [63:0] sx(input logic [31:0] w);
    return {{32{w[31]}}, w};
  endfunction

  function automatic mnem_e identify(input logic [31:0] ins);
    casez (ins)
      32'b0000000_?????_?????_000_?????_0110011: return ADD;
      32'b0100000_?????_?????_000_?????_0110011: return SUB;
      32'b0000000_?????_?????_001_?????_0110011: return SLL;
      32'b0000000_?????_?????_010_?????_0110011: return SLT;
      32'b0000000_?????_?????_011_?????_0110011: return SLTU;
      32'b0000000_?????_?????_100_?????_0110011: return XOR_;
      32'b0000000_?????_?????_101_?????_0110011: return SRL;
      32'b0100000_?????_?????_101_?????_0110011: return SRA;
      32'b0000000_?????_?????_110_?????_0110011: return OR_;
      32'b0000000_?????_?????_111_?????_0110011: return AND_;
      32'b???????_?????_?????_000_?????_0010011: return ADDI;
      32'b???????_?????_?????_010_?????_0010011: return SLTI;
      32'b???????_?????_?????_011_?????_0010011: return SLTIU;
      32'b???????_?????_?????_100_?????_0010011: return XORI;
      32'b???????_?????_?????_110_?????_0010011: return ORI;
      32'b???????_?????_?????_111_?????_0010011: return ANDI;
      32'b000000?_?????_?????_001_?????_0010011: return SLLI;
      32'b000000?_?????_?????_101_?????_0010011: return SRLI;
      32'b010000?_?????_?????_101_?????_0010011: return SRAI;
      32'b0000000_?????_?????_000_?????_0111011: return ADDW;
      32'b0100000_?????_?????_000_?????_0111011: return SUBW;
      32'b0000000_?????_?????_001_?????_0111011: return SLLW;
      32'b0000000_?????_?????_101_?????_0111011: return SRLW;
      32'b0100000_?????_?????_101_?????_0111011: return SRAW;
      32'b???????_?????_?????_000_?????_0011011: return ADDIW;
      32'b0000000_?????_?????_001_?????_0011011: return SLLIW;
      32'b0000000_?????_?????_101_?????_0011011: return SRLIW;
      32'b0100000_?????_?????_101_?????_0011011: return SRAIW;
      32'b???????_?????_?????_???_?????_0110111: return LUI;
      default: return BAD;
    endcase
  endfunction

  task automatic ref_exec(input logic [31:0] ins, output mnem_e m, output logic [63:0] v,
                          output logic [3:0] op);
    logic [63:0] a, b, i;
    logic [5:0]  sh6;
    logic [4:0]  sh5;
    a   = m_regs[ins[19:15]];
    b   = m_regs[ins[24:20]];
    i   = {{52{ins[31]}}, ins[31:20]};
    sh6 = ins[25:20];
    sh5 = ins[24:20];
    m   = identify(ins);
    v   = '0;
    op  = 4'd0;
    case (m)
      ADD:   begin v = a + b;                              op = 4'd0; end
      SUB:   begin v = a - b;                              op = 4'd1; end
      SLL:   begin v = a << b[5:0];                        op = 4'd2; end
      SLT:   begin v = ($signed(a) < $signed(b)) ? 1 : 0;  op = 4'd3; end
      SLTU:  begin v = (a < b) ? 1 : 0;                    op = 4'd4; end
      XOR_:  begin v = a ^ b;                              op = 4'd5; end
      SRL:   begin v = a >> b[5:0];                        op = 4'd6; end
      SRA:   begin v = $signed(a) >>> b[5:0];              op = 4'd7; end
      OR_:   begin v = a | b;                              op = 4'd8; end
      AND_:  begin v = a & b;                              op = 4'd9; end
      ADDI:  begin v = a + i;                              op = 4'd0; end
      SLTI:  begin v = ($signed(a) < $signed(i)) ? 1 : 0;  op = 4'd3; end
      SLTIU: begin v = (a < i) ? 1 : 0;                    op = 4'd4; end
      XORI:  begin v = a ^ i;                              op = 4'd5; end
      ORI:   begin v = a | i;                              op = 4'd8; end
      ANDI:  begin v = a & i;                              op = 4'd9; end
      SLLI:  begin v = a << sh6;                           op = 4'd2; end
      SRLI:  begin v = a >> sh6;                           op = 4'd6; end
      SRAI:  begin v = $signed(a) >>> sh6;                 op = 4'd7; end
      ADDW:  begin v = sx(a[31:0] + b[31:0]);              op = 4'd0; end
      SUBW:  begin v = sx(a[31:0] - b[31:0]);              op = 4'd1; end
      SLLW:  begin v = sx(a[31:0] << b[4:0]);              op = 4'd2; end
      SRLW:  begin v = sx(a[31:0] >> b[4:0]);              op = 4'd6; end
      SRAW:  begin v = sx($signed(a[31:0]) >>> b[4:0]);    op = 4'd7; end
      ADDIW: begin v = sx(a[31:0] + i[31:0]);              op = 4'd0; end
      SLLIW: begin v = sx(a[31:0] << sh5);                 op = 4'd2; end
      SRLIW: begin v = sx(a[31:0] >> sh5);                 op = 4'd6; end
      SRAIW: begin v = sx($signed(a[31:0]) >>> sh5);       op = 4'd7; end
      LUI:   begin v = {{32{ins[31]}}, ins[31:12], 12'h000}; op = 4'd10; end
      default: ;
    endcase
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_dbg(input logic [4:0] a, input logic [63:0] exp, input string tag);
    dbg_addr = a;
    #1;
    check_output(tag, dbg_data, exp);
  endtask

  // Applies one instruction for one clock, checking decode before the edge
  // and writeback state after it.
  task automatic apply_stimulus(input logic [31:0] ins, input logic valid, input logic rst_n);
    mnem_e       m;
    logic [63:0] v;
    logic [3:0]  op;
    logic [31:0] exp_imm;
    logic [5:0]  exp_sh;
    instruction = ins;
    instr_valid = valid;
    reset       = rst_n;
    dbg_addr    = ins[11:7];
    #1;
    ref_exec(ins, m, v, op);
    case (ins[6:0])
      7'b0010011, 7'b0011011: exp_imm = {{20{ins[31]}}, ins[31:20]};
      7'b0110111:             exp_imm = {ins[31:12], 12'h000};
      default:                exp_imm = '0;
    endcase
    exp_sh = ins[25:20];
    if ((ins[6:0] == 7'b0111011 || ins[6:0] == 7'b0011011) &&
        (ins[14:12] == 3'd1 || ins[14:12] == 3'd5))
      exp_sh[5] = 1'b0;
    check_output("illegal", illegal, (m == BAD) ? 1 : 0);
    check_output("immediate", immediate, exp_imm);
    check_output("shamt", shamt, exp_sh);
    check_output("fields", {rd, rs1, rs2}, {ins[11:7], ins[19:15], ins[24:20]});
    if (m != BAD) check_output("alu_op", alu_op, op);
    if (m_known) check_output("dbg_pre", dbg_data, m_regs[ins[11:7]]);
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) m_regs[r] = '0;
      m_result   = '0;
      m_wb_rd    = '0;
      m_wb_valid = 1'b0;
      m_known    = 1;
    end else if (valid && m != BAD) begin
      if (ins[11:7] != 5'd0) m_regs[ins[11:7]] = v;
      m_result   = v;
      m_wb_rd    = ins[11:7];
      m_wb_valid = 1'b1;
    end else begin
      m_wb_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check_output("wb_valid", wb_valid, m_wb_valid);
    check_output("wb_rd", wb_rd, m_wb_rd);
    check_output("result", result, m_result);
    check_output("dbg_post", dbg_data, m_regs[ins[11:7]]);
  endtask

  initial begin
    logic [31:0] ins;
    logic        valid;
    reset       = 1'b0;
    instr_valid = 1'b0;
    instruction = '0;
    dbg_addr    = '0;

    apply_stimulus(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 1'b1, 1'b0);
    for (int r = 0; r < 32; r++) check_dbg(r[4:0], 64'd0, "reset_reg");
    check_output("reset_wb_valid", wb_valid, 1'b0);
    check_output("reset_result", result, 64'd0);

    apply_stimulus(32'hFFB00093, 1'b1, 1'b1);
    check_output("addi_imm", immediate, 32'hFFFFFFFB);
    apply_stimulus(enc_i(12'd7, 5'd0, 3'd0, 5'd2, 7'h13), 1'b1, 1'b1);
    check_dbg(5'd1, 64'hFFFFFFFFFFFFFFFB, "x1");
    check_dbg(5'd2, 64'd7, "x2");

    apply_stimulus(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 1'b1, 1'b1);
    apply_stimulus(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4, 7'h33), 1'b1, 1'b1);
    apply_stimulus(enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd5, 7'h33), 1'b1, 1'b1);
    apply_stimulus(enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd6, 7'h33), 1'b1, 1'b1);
    check_dbg(5'd3, 64'd2, "add");
    check_dbg(5'd4, 64'hFFFFFFFFFFFFFFF4, "sub");
    check_dbg(5'd5, 64'd1, "slt");
    check_dbg(5'd6, 64'd0, "sltu");

    apply_stimulus(enc_i(12'h43F, 5'd1, 3'd5, 5'd7, 7'h13), 1'b1, 1'b1);
    apply_stimulus(enc_i(12'h03C, 5'd1, 3'd5, 5'd8, 7'h13), 1'b1, 1'b1);
    apply_stimulus(enc_u(20'h80000, 5'd9, 7'h37), 1'b1, 1'b1);
    apply_stimulus(enc_i(12'hFFF, 5'd9, 3'd0, 5'd10, 7'h1B), 1'b1, 1'b1);
    check_dbg(5'd7, 64'hFFFFFFFFFFFFFFFF, "srai");
    check_dbg(5'd8, 64'h000000000000000F, "srli");
    check_dbg(5'd9, 64'hFFFFFFFF80000000, "lui");
    check_dbg(5'd10, 64'h000000007FFFFFFF, "addiw");

    apply_stimulus(enc_i(12'd5, 5'd0, 3'd0, 5'd0, 7'h13), 1'b1, 1'b1);
    check_output("x0_wb_valid", wb_valid, 1'b1);
    check_output("x0_result", result, 64'd5);
    check_dbg(5'd0, 64'd0, "x0_stays_zero");

    apply_stimulus(32'h00000000, 1'b1, 1'b1);
    check_output("zero_illegal", illegal, 1'b1);
    check_output("zero_wb_valid", wb_valid, 1'b0);
    check_dbg(5'd1, 64'hFFFFFFFFFFFFFFFB, "zero_no_write");

    apply_stimulus(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd11, 7'h33), 1'b1, 1'b0);
    check_output("rst_wb_valid", wb_valid, 1'b0);
    check_dbg(5'd11, 64'd0, "rst_discard");
    check_dbg(5'd3, 64'd0, "rst_clears");

    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      case ($urandom_range(0, 9))
        0, 1: begin
          ins[6:0]   = 7'h33;
          ins[31:25] = ($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00;
        end
        2, 3: begin
          ins[6:0] = 7'h13;
          if (ins[14:12] == 3'd1 || ins[14:12] == 3'd5)
            ins[31:26] = ($urandom_range(0, 2) == 0) ? 6'h10 : 6'h00;
        end
        4: begin
          ins[6:0]   = 7'h3B;
          ins[31:25] = ($urandom_range(0, 2) == 0) ? 7'h20 : 7'h00;
        end
        5: begin
          ins[6:0]   = 7'h1B;
          ins[31:25] = ($urandom_range(0, 2) == 0) ? 7'h20 : 7'h00;
        end
        6: ins[6:0] = 7'h37;
        7: ;
        default: begin
          ins[6:0]   = 7'h13;
          ins[14:12] = 3'd0;
        end
      endcase
      valid = ($urandom_range(0, 7) != 0);
      apply_stimulus(ins, valid, (n == 200) ? 1'b0 : 1'b1);
    end

    instr_valid = 1'b0;
    for (int r = 0; r < 32; r++) check_dbg(r[4:0], m_regs[r], "final_reg");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
